router_egress_arb: RTL and testbench

ROUTER_EGRESS_ARB -- requirements
Module: router_egress_arb

---
 rtl/router_egress_arb_pkg.sv | 23 ++
 rtl/router_rr_pick.sv | 31 +++
 rtl/router_egress_arb.sv | 123 ++++++++++++
 tb/tb_router_egress_arb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_egress_arb_pkg.sv
// Shared definitions for the egress arbiter: port count, state encodings,
// stall timeout default and header length field position.
package router_egress_arb_pkg;

    localparam int unsigned NPORT       = 3;
    localparam int unsigned TIMEOUT_DEF = 30;
    localparam int unsigned HDR_LEN_MSB = 7;
    localparam int unsigned HDR_LEN_LSB = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_BODY  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // last_grant reset value: pointing at the top port makes port 0 win first
    localparam logic [NPORT-1:0] LAST_GRANT_RST = 3'b100;

    // Words still to pop after the header: L payload bytes plus parity.
    function automatic logic [6:0] hdr_remaining(input logic [7:0] hdr);
        return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin select: searches from the port after last_i
// and returns a one-hot pick (all-zero when nothing requests).
module router_rr_pick
    import router_egress_arb_pkg::*;
(
    input  logic [NPORT-1:0] req_i,
    input  logic [NPORT-1:0] last_i,
    output logic [NPORT-1:0] pick_o
);

    always_comb begin
        int unsigned base;
        int unsigned idx;
        pick_o = '0;
        case (last_i)
            3'b001:  base = 1;
            3'b010:  base = 2;
            default: base = 0;
        endcase
        idx = 0;
        // Walk lowest priority first so the highest-priority hit is written last.
        for (int unsigned k = NPORT; k > 0; k--) begin
            idx = (base + k - 1) % NPORT;
            if (req_i[idx]) begin
                pick_o      = '0;
                pick_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_egress_arb.sv
// Packet-granular egress arbiter: moves whole packets from three FIFOs onto a
// shared egress port, flushing a FIFO whose egress stalls for TIMEOUT cycles.
module router_egress_arb
    import router_egress_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NPORT-1:0] fifo_empty,
    input  logic [7:0]       data_0,
    input  logic [7:0]       data_1,
    input  logic [7:0]       data_2,
    output logic [NPORT-1:0] read_enb,
    input  logic             egress_ready,
    output logic [7:0]       data_out,
    output logic             vld_out,
    output logic [NPORT-1:0] grant,
    output logic [NPORT-1:0] soft_reset,
    output logic             busy
);

    localparam int unsigned SW = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    logic [NPORT-1:0] grant_q, grant_d;
    logic [NPORT-1:0] last_q, last_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [SW-1:0]    stall_q, stall_d;

    logic [NPORT-1:0] pick;
    logic [7:0]       head;
    logic             active;
    logic             pop;
    logic [SW-1:0]    stall_inc;

    router_rr_pick u_pick (
        .req_i  (~fifo_empty),
        .last_i (last_q),
        .pick_o (pick)
    );

    always_comb begin
        case (grant_q)
            3'b001:  head = data_0;
            3'b010:  head = data_1;
            3'b100:  head = data_2;
            default: head = 8'h00;
        endcase
        active     = (state_q == ST_HDR) || (state_q == ST_BODY);
        vld_out    = active && |(grant_q & ~fifo_empty);
        pop        = vld_out && egress_ready;
        read_enb   = pop ? grant_q : '0;
        data_out   = vld_out ? head : 8'h00;
        grant      = grant_q;
        soft_reset = (state_q == ST_FLUSH) ? grant_q : '0;
        busy       = (state_q != ST_IDLE);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        stall_inc = stall_q + SW'(1);
        case (state_q)
            ST_IDLE: begin
                if (|pick) begin
                    grant_d = pick;
                    stall_d = '0;
                    state_d = ST_HDR;
                end
            end
            ST_HDR, ST_BODY: begin
                // A pop in the timeout cycle still counts as progress.
                if (pop) begin
                    stall_d = '0;
                    if (state_q == ST_HDR) begin
                        cnt_d   = hdr_remaining(head);
                        state_d = ST_BODY;
                    end else if (cnt_q == 7'd1) begin
                        cnt_d   = '0;
                        last_d  = grant_q;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 7'd1;
                    end
                end else begin
                    stall_d = stall_inc;
                    if (stall_inc == SW'(TIMEOUT)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            default: begin
                last_d  = grant_q;
                grant_d = '0;
                cnt_d   = '0;
                stall_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_GRANT_RST;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_router_egress_arb.sv
// Directed bench for router_egress_arb with three first-word-fall-through
// FIFO models feeding the arbiter.
module tb_router_egress_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] fifo_empty;
    logic [7:0] data_0, data_1, data_2;
    logic [2:0] read_enb;
    logic       egress_ready = 1'b0;
    logic [7:0] data_out;
    logic       vld_out;
    logic [2:0] grant;
    logic [2:0] soft_reset;
    logic       busy;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [7:0] mem [3][512];
    int wp [3] = '{0, 0, 0};
    int rp [3] = '{0, 0, 0};

    router_egress_arb #(.TIMEOUT(30)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .data_0       (data_0),
        .data_1       (data_1),
        .data_2       (data_2),
        .read_enb     (read_enb),
        .egress_ready (egress_ready),
        .data_out     (data_out),
        .vld_out      (vld_out),
        .grant        (grant),
        .soft_reset   (soft_reset),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < 3; p++) fifo_empty[p] = (rp[p] == wp[p]);
    end
    assign data_0 = mem[0][rp[0] % 512];
    assign data_1 = mem[1][rp[1] % 512];
    assign data_2 = mem[2][rp[2] % 512];

    always @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (soft_reset[p]) rp[p] <= wp[p];
            else if (read_enb[p]) rp[p] <= rp[p] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input logic [7:0] b);
        mem[p][wp[p] % 512] = b;
        wp[p] = wp[p] + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_vld"}, 32'(vld_out), 32'd0);
        chk({tag, "_renb"}, 32'(read_enb), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_b [65];
        int n;
        int pops;
        int derr;
        logic flushed;

        // Reset state
        #12;
        chk_idle("rst");
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_srst", 32'(soft_reset), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // L=3 packet on port 0, ready held high
        push(0, 8'h0C); push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h3C);
        egress_ready = 1'b1;
        #1;
        chk("t1_pre_vld", 32'(vld_out), 32'd0);
        tick();
        exp_b[0] = 8'h0C; exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33; exp_b[4] = 8'h3C;
        for (int w = 0; w < 5; w++) begin
            chk("t1_vld", 32'(vld_out), 32'd1);
            chk("t1_renb", 32'(read_enb), 32'b001);
            chk("t1_data", 32'(data_out), 32'(exp_b[w]));
            tick();
        end
        chk_idle("t1_end");

        // Three L=1 packets after reset: served 0,1,2 with a bubble between
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push(0, 8'h04); push(0, 8'hA0); push(0, 8'hB0);
        push(1, 8'h05); push(1, 8'hA1); push(1, 8'hB1);
        push(2, 8'h06); push(2, 8'hA2); push(2, 8'hB2);
        tick();
        for (int p = 0; p < 3; p++) begin
            exp_b[0] = 8'h04 + 8'(p); exp_b[1] = 8'hA0 + 8'(p); exp_b[2] = 8'hB0 + 8'(p);
            for (int w = 0; w < 3; w++) begin
                chk("t2_grant", 32'(grant), 32'(1 << p));
                chk("t2_renb", 32'(read_enb), 32'(1 << p));
                chk("t2_data", 32'(data_out), 32'(exp_b[w]));
                tick();
            end
            chk_idle("t2_bubble");
            tick();
        end

        // L=0 packet on port 1: header then parity only
        push(1, 8'h01); push(1, 8'h5A);
        tick();
        chk("t3_hdr_renb", 32'(read_enb), 32'b010);
        chk("t3_hdr_data", 32'(data_out), 32'h01);
        tick();
        chk("t3_par_renb", 32'(read_enb), 32'b010);
        chk("t3_par_data", 32'(data_out), 32'h5A);
        tick();
        chk_idle("t3_end");
        tick();
        chk("t3_stay_idle", 32'(busy), 32'd0);

        // Port 2 stalls for TIMEOUT cycles, then port 0 is served
        push(2, 8'h0A); push(2, 8'hC1); push(2, 8'hC2); push(2, 8'hC3);
        push(0, 8'h00); push(0, 8'hEE);
        egress_ready = 1'b0;
        tick();
        chk("t4_grant", 32'(grant), 32'b100);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (soft_reset != 3'b000) break;
            if (vld_out && read_enb == 3'b000) n++;
            tick();
        end
        chk("t4_stall_cycles", 32'(n), 32'd30);
        chk("t4_srst", 32'(soft_reset), 32'b100);
        chk("t4_flush_vld", 32'(vld_out), 32'd0);
        chk("t4_flush_busy", 32'(busy), 32'd1);
        tick();
        chk("t4_srst_once", 32'(soft_reset), 32'd0);
        chk("t4_grant_clr", 32'(grant), 32'd0);
        egress_ready = 1'b1;
        tick();
        chk("t4_next_grant", 32'(grant), 32'b001);
        chk("t4_next_data", 32'(data_out), 32'h00);
        tick();
        chk("t4_next_par", 32'(data_out), 32'hEE);
        tick();
        chk_idle("t4_end");

        // L=63 packet with egress_ready toggling every cycle
        push(0, 8'hFC);
        for (int i = 1; i <= 63; i++) push(0, 8'(i));
        push(0, 8'hA5);
        egress_ready = 1'b0;
        tick();
        pops = 0; derr = 0; flushed = 1'b0;
        for (int c = 0; c < 300 && busy; c++) begin
            egress_ready = ((c % 2) == 1);
            #1;
            if (read_enb != 3'b000) begin
                if (pops == 0 && data_out !== 8'hFC) derr++;
                else if (pops >= 1 && pops <= 63 && data_out !== 8'(pops)) derr++;
                else if (pops == 64 && data_out !== 8'hA5) derr++;
                pops++;
            end
            if (soft_reset != 3'b000) flushed = 1'b1;
            tick();
        end
        chk("t5_pops", 32'(pops), 32'd65);
        chk("t5_data_errs", 32'(derr), 32'd0);
        chk("t5_no_flush", 32'(flushed), 32'd0);
        chk("t5_end_busy", 32'(busy), 32'd0);

        // Reset in mid-BODY, then port 0 wins first
        egress_ready = 1'b1;
        push(1, 8'h0D); push(1, 8'h01); push(1, 8'h02); push(1, 8'h03); push(1, 8'h99);
        push(0, 8'h00); push(0, 8'h77);
        tick();
        chk("t6_grant", 32'(grant), 32'b010);
        tick();
        tick();
        chk("t6_mid_body", 32'(data_out), 32'h02);
        reset = 1'b1;
        #1;
        chk_idle("t6_rst");
        chk("t6_rst_dout", 32'(data_out), 32'd0);
        chk("t6_rst_srst", 32'(soft_reset), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_first_grant", 32'(grant), 32'b001);
        chk("t6_first_data", 32'(data_out), 32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
